cache_access_controller: RTL
============================

Name: cache_access_controller

Overview:
- Sequences read accesses into the 16-block direct-mapped cache (cache_read / cache_addr in, registered hit out one cycle later) on behalf of two requesters.
- Provides round-robin arbitration, a one-transaction-at-a-time FSM and a miss-refill handshake to backing memory.
- Maintains saturating hit/miss statistics.
- Sits between the requester ports and the cache plus memory model in the simulator top level.

Parameters:
- ADDR_W, 11, address width shared with the cache.
- OFFSET_W, 4, block offset bits; mem_addr low OFFSET_W bits forced to 0.
- CNT_W, 16, width of the hit/miss statistics counters.
- MEM_TIMEOUT, 64, max REFILL cycles waiting for mem_ack before aborting (must be ≥ 2).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 access request, level, held until done0.
- addr0  in  ADDR_W  requester 0 address, stable while req0 high.
- req1  in  1  requester 1 access request.
- addr1  in  ADDR_W  requester 1 address.
- done0  out  1  one-cycle completion pulse to requester 0.
- done1  out  1  one-cycle completion pulse to requester 1.
- resp_hit  out  1  valid with done*: 1 = cache hit, 0 = miss serviced.
- resp_err  out  1  valid with done*: 1 = refill timed out.
- cache_read  out  1  read strobe to cache, one cycle per transaction.
- cache_addr  out  ADDR_W  address to cache.
- cache_hit  in  1  cache hit flag, registered by cache, valid the cycle after cache_read.
- mem_req  out  1  refill request to memory, held until mem_ack or timeout.
- mem_addr  out  ADDR_W  block-aligned refill address.
- mem_ack  in  1  memory refill complete, one-cycle pulse.
- busy  out  1  high in every state except IDLE.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; round-robin pointer goes to 0.
  - Every output is 0: done*, resp_*, cache_read, cache_addr, mem_req, mem_addr, busy, counters.
  - Reset mid-transaction abandons it. No done is issued. mem_req drops in the cycle after the reset edge.
- States: IDLE, ISSUE, WAIT, REFILL, DONE. All outputs are registered.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester named by the pointer.
  - On grant: latch id and address, drive cache_addr = latched address, go to ISSUE.
  - After every grant the pointer = the other id.
- ISSUE: cache_read = 1 for exactly this cycle; go to WAIT.
- WAIT: sample cache_hit.
  - 1: hit_count += 1, resp_hit = 1, go to DONE.
  - 0: miss_count += 1, go to REFILL with mem_req = 1 and mem_addr = {addr[ADDR_W-1:OFFSET_W], OFFSET_W'b0}.
- REFILL:
  - mem_req stays high and a timeout counter increments each cycle.
  - mem_ack = 1: drop mem_req, resp_hit = 0, resp_err = 0, go to DONE.
  - Counter reaches MEM_TIMEOUT without ack: drop mem_req, resp_err = 1, go to DONE.
- DONE: pulse done of the latched id for one cycle, with resp_hit / resp_err held for that cycle; return to IDLE.
- Latency from the IDLE cycle seeing req: hit → done 3 cycles later; miss → 4 + (ack delay) cycles.
- Requester protocol:
  - Requester drops req at the edge where it samples done high.
  - req still high in the cycle after done counts as a new request.
  - addr changes while req is high and not yet done are ignored after grant.
- mem_ack outside REFILL is ignored. An ack arriving in the same cycle the timeout expires is treated as ack (no error).
- Counters saturate at all-ones and never wrap.
- cache_addr and mem_addr hold their last value between transactions.

Test Plan:
- Reset, then req0 addr0=0x123 (cold miss), mem_ack 5 cycles after mem_req → mem_addr=0x120, done0 with resp_hit=0, miss_count=1.
- Repeat req0 addr0=0x12F → cache_read one cycle, done0 exactly 3 cycles after the IDLE sample, resp_hit=1, hit_count=1, mem_req never asserted.
- req0 and req1 asserted the same cycle, held and re-asserted for 4 transactions → grants strictly alternate 0,1,0,1 starting with 0; at most one done per cycle.
- Miss with mem_ack never returned, MEM_TIMEOUT=64 → mem_req high 64 cycles then low, done with resp_err=1, FSM back to IDLE, a subsequent hit is unaffected.
- rst pulsed while in REFILL → mem_req low the cycle after the reset edge, no done, counters 0, next req served normally from IDLE.
- Force hit_count to saturate (CNT_W=4 build, 17 hits) → hit_count holds 15.

Source files
------------

// File: rtl/cache_access_controller.sv
// cache_access_controller: two-requester round-robin front end for a
// direct-mapped cache, with miss refill to backing memory and statistics.
module cache_access_controller #(
  parameter int ADDR_W      = 11,
  parameter int OFFSET_W    = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              done0,
  output logic              done1,
  output logic              resp_hit,
  output logic              resp_err,
  output logic              cache_read,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              busy,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_REFILL,
    S_DONE
  } state_t;

  state_t            r_state, w_state;
  logic              r_ptr, w_ptr;
  logic              r_id, w_id;
  logic              w_gid;
  logic [TMO_W-1:0]  r_tmo, w_tmo;
  logic              r_done0, w_done0;
  logic              r_done1, w_done1;
  logic              r_hit, w_hit;
  logic              r_err, w_err;
  logic              r_crd, w_crd;
  logic [ADDR_W-1:0] r_caddr, w_caddr;
  logic              r_mreq, w_mreq;
  logic [ADDR_W-1:0] r_maddr, w_maddr;
  logic              r_busy, w_busy;
  logic [CNT_W-1:0]  r_hcnt, w_hcnt;
  logic [CNT_W-1:0]  r_mcnt, w_mcnt;

  assign done0      = r_done0;
  assign done1      = r_done1;
  assign resp_hit   = r_hit;
  assign resp_err   = r_err;
  assign cache_read = r_crd;
  assign cache_addr = r_caddr;
  assign mem_req    = r_mreq;
  assign mem_addr   = r_maddr;
  assign busy       = r_busy;
  assign hit_count  = r_hcnt;
  assign miss_count = r_mcnt;

  // Next state and next value of every registered output
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_id    = r_id;
    w_gid   = 1'b0;
    w_tmo   = r_tmo;
    w_done0 = 1'b0;
    w_done1 = 1'b0;
    w_hit   = 1'b0;
    w_err   = 1'b0;
    w_crd   = 1'b0;
    w_caddr = r_caddr;
    w_mreq  = 1'b0;
    w_maddr = r_maddr;
    w_hcnt  = r_hcnt;
    w_mcnt  = r_mcnt;
    unique case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_gid   = (req0 && req1) ? r_ptr : req1;
          w_id    = w_gid;
          w_caddr = w_gid ? addr1 : addr0;
          w_ptr   = ~w_gid;
          w_crd   = 1'b1;
          w_state = S_ISSUE;
        end
      end
      S_ISSUE: w_state = S_WAIT;
      S_WAIT: begin
        if (cache_hit) begin
          w_hcnt  = (&r_hcnt) ? r_hcnt : r_hcnt + 1'b1;
          w_hit   = 1'b1;
          w_state = S_DONE;
        end else begin
          w_mcnt  = (&r_mcnt) ? r_mcnt : r_mcnt + 1'b1;
          w_mreq  = 1'b1;
          w_maddr = {r_caddr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          w_tmo   = '0;
          w_state = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_ack) begin
          w_state = S_DONE;
        end else if (r_tmo == TMO_LAST) begin
          w_err   = 1'b1;
          w_state = S_DONE;
        end else begin
          w_mreq = 1'b1;
          w_tmo  = r_tmo + 1'b1;
        end
      end
      S_DONE: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
    if (w_state == S_DONE) begin
      w_done0 = ~r_id;
      w_done1 = r_id;
    end
    w_busy = (w_state != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_id    <= 1'b0;
      r_tmo   <= '0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_hit   <= 1'b0;
      r_err   <= 1'b0;
      r_crd   <= 1'b0;
      r_caddr <= '0;
      r_mreq  <= 1'b0;
      r_maddr <= '0;
      r_busy  <= 1'b0;
      r_hcnt  <= '0;
      r_mcnt  <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_id    <= w_id;
      r_tmo   <= w_tmo;
      r_done0 <= w_done0;
      r_done1 <= w_done1;
      r_hit   <= w_hit;
      r_err   <= w_err;
      r_crd   <= w_crd;
      r_caddr <= w_caddr;
      r_mreq  <= w_mreq;
      r_maddr <= w_maddr;
      r_busy  <= w_busy;
      r_hcnt  <= w_hcnt;
      r_mcnt  <= w_mcnt;
    end
  end

endmodule
